// File: rtl/main_mem_ctrl.sv
// Main-memory controller: single-word read/write port in front of a word RAM,
// with a programmable wait-state latency and completion/statistics outputs.
module main_mem_ctrl #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] mem_a,
  input  logic [31:0] mem_st_data,
  input  logic        mem_access,
  input  logic        mem_write,
  output logic [31:0] mem_data,
  output logic        mem_ready,
  output logic        busy,
  output logic [15:0] n_reads,
  output logic [15:0] n_writes
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READY
  } state_t;

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_t                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   idx_q, idx_d;
  logic                   wr_q, wr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [15:0]            n_reads_q, n_reads_d;
  logic [15:0]            n_writes_q, n_writes_d;
  logic                   ram_we;

  logic [31:0] ram [0:(1<<ADDR_BITS)-1];

  logic unused_a;
  assign unused_a = ^{mem_a[31:ADDR_BITS+2], mem_a[1:0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    n_reads_d  = n_reads_q;
    n_writes_d = n_writes_q;
    ram_we     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_access) begin
          idx_d   = mem_a[ADDR_BITS+1:2];
          wr_d    = mem_write;
          wdata_d = mem_st_data;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!mem_access) begin
          state_d = IDLE;
        end else if (cnt_q == 8'd0) begin
          state_d = READY;
          if (wr_q) begin
            ram_we     = 1'b1;
            n_writes_d = n_writes_q + 16'd1;
          end else begin
            rdata_d   = ram[idx_q];
            n_reads_d = n_reads_q + 16'd1;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      READY: begin
        // Access still high here belongs to the request just finished.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      idx_q      <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      n_reads_q  <= 16'd0;
      n_writes_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      n_reads_q  <= n_reads_d;
      n_writes_q <= n_writes_d;
    end
  end

  // RAM keeps its contents across reset; reset only blocks the commit.
  always_ff @(posedge clk) begin
    if (ram_we && !clr) begin
      ram[idx_q] <= wdata_q;
    end
  end

  assign mem_data  = rdata_q;
  assign mem_ready = (state_q == READY);
  assign busy      = (state_q != IDLE);
  assign n_reads   = n_reads_q;
  assign n_writes  = n_writes_q;

endmodule

// File: doc/main_mem_ctrl.md
Name: main_mem_ctrl

Overview:
- Main-memory side of the CPU/cache/TLB memory bus. Sits directly downstream of the CPU's cache miss and write-through port.
- Accepts single-word requests on mem_access, mem_write, mem_a and mem_st_data. Services each request against an internal word RAM after a programmable wait-state latency.
- Returns the read data on mem_data with a one-cycle mem_ready pulse. This is the cycle in which the cache fills or retires its write.

Parameters:
- ADDR_BITS, 10, log2 of RAM depth in 32-bit words; RAM index = mem_a[ADDR_BITS+1:2].
- LATENCY, 4, wait states from request acceptance to mem_ready; legal 1..255.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- clr  input  1  reset, synchronous, active-high.
- mem_a  input  32  byte address; bits [1:0] and bits above ADDR_BITS+1 ignored.
- mem_st_data  input  32  write data.
- mem_access  input  1  request valid; held high by the cache until mem_ready is seen.
- mem_write  input  1  1 = write, 0 = read; qualified by mem_access.
- mem_data  output  32  registered read data.
- mem_ready  output  1  one-cycle completion pulse.
- busy  output  1  high whenever state != IDLE.
- n_reads  output  16  completed read count; wraps at 0xFFFF -> 0.
- n_writes  output  16  completed write count; wraps at 0xFFFF -> 0.

Behaviour:
- Reset (clr=1 at an edge): state=IDLE, cnt=0, mem_ready=0, mem_data=0, busy=0, n_reads=0, n_writes=0. RAM contents are not cleared.
- Reset has priority over every other event. Reset mid-request aborts that request; a pending write is never committed.
- The controller has three states: IDLE, WAIT and READY.
- IDLE:
  - If mem_access=1 at edge E0: latch index, mem_write and mem_st_data; load cnt=LATENCY-1; go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - If mem_access=0: abort to IDLE. No RAM write, no counter change, no mem_ready.
  - Else if cnt==0: go to READY.
  - Else cnt <= cnt-1.
- Entry into READY (same edge):
  - Latched write: RAM[index] <= latched data; n_writes++; mem_data unchanged.
  - Latched read: mem_data <= RAM[index]; n_reads++.
- READY:
  - mem_ready=1 for exactly this cycle.
  - Next edge always returns to IDLE. mem_access sampled in READY is ignored; it belongs to the request just completed.
- Timing: with acceptance at edge E0, mem_ready is high between edges E(LATENCY) and E(LATENCY+1).
- Throughput: at most one access per LATENCY+2 cycles. A back-to-back request is accepted at the first IDLE edge.
- Request fields are latched at acceptance. Changes to mem_a, mem_write or mem_st_data during WAIT have no effect.
- Read-after-write to the same index returns the newly written value.
- mem_data holds its last read value through IDLE, WAIT and write completions.
- mem_ready is never asserted in IDLE or WAIT. mem_ready=1 implies busy=1.
- LATENCY=1: mem_ready is high between E1 and E2.

Test Plan:
- Reset: drive clr=1 for 2 cycles while mem_access=1 -> mem_ready=0, mem_data=0, busy=0, n_reads=n_writes=0; no request accepted during reset.
- Write/read, LATENCY=4: write 0xDEADBEEF to mem_a=0x40, accepted at E0 -> mem_ready high only between E4 and E5; n_writes=1. Then read 0x40 -> mem_data=0xDEADBEEF in the ready cycle; n_reads=1.
- Aliasing and held data: with ADDR_BITS=10, write 0x12345678 at 0x1000, then read 0x0000 -> returns 0x12345678. Afterwards mem_data stays 0x12345678 through 3 idle cycles and a following write.
- Abort: drop mem_access at E2 of a write of 0xAAAA5555 to 0x80 -> busy=0 after E3; no mem_ready. A later read of 0x80 returns the prior contents; n_writes unchanged.
- Reset mid-request: assert clr at E2 of a write of 0x0F0F0F0F to 0x84 -> busy=0 after that edge; no mem_ready. A later read of 0x84 returns the prior contents; all outputs at reset values.
- Back-to-back and wrap, LATENCY=1:
  - Two reads with mem_access held continuously -> ready pulses 3 cycles apart; second ready never in the IDLE cycle.
  - Preset n_reads to 0xFFFF via 65535 reads -> the next read gives n_reads=0x0000.
